// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared constants, state encoding and slot-address packing for fetch_pc_gen
package fetch_pc_gen_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam int          SEQ_W                = 3;
    localparam int          NUM_SLOTS            = 4;
    localparam int          SLOT_ADDR_W          = 32;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DSLOT  = 1'b1
    } pcg_state_e;

    // Slot i lives in bits [32i+31:32i]; the BTB unpacks with the same layout.
    function automatic logic [NUM_SLOTS*SLOT_ADDR_W-1:0] pack_slot_addrs(input logic [31:0] pc);
        logic [NUM_SLOTS*SLOT_ADDR_W-1:0] packed_addrs;
        packed_addrs = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            packed_addrs[SLOT_ADDR_W*i +: SLOT_ADDR_W] = {pc[31:4], 2'(i), pc[1:0]};
        end
        return packed_addrs;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator: one 16-byte group per cycle with MIPS delay-slot sequencing
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 BCK_redirect_i,
    input  logic [31:0]          BCK_redirectDest_i,
    input  logic                 IF_ready_i,
    input  logic [31:0]          BTB_validDest_i,
    input  logic                 BTB_validTake_i,
    input  logic                 BTB_needDelaySlot_i,
    input  logic [31:0]          BTB_fifthVAddr_i,
    output logic [127:0]         PCG_VAddr_p_o,
    output logic [3:0]           PCG_instEnable_o,
    output logic                 PCG_needDelaySlot_o,
    output logic                 PCG_valid_o,
    output logic [SEQ_W-1:0]     PCG_seq_o,
    output logic                 PCG_epoch_o
);

    localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

    // NORMAL enables the entry slot and everything after it; DSLOT enables only the delay slot.
    function automatic logic [NUM_SLOTS-1:0] slot_mask(input pcg_state_e st, input logic [1:0] slot);
        logic [NUM_SLOTS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (st == ST_DSLOT) begin
                m[i] = (i == int'(slot));
            end else begin
                m[i] = (i >= int'(slot));
            end
        end
        return m;
    endfunction

    pcg_state_e        state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       saved_dest_q, saved_dest_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              epoch_q, epoch_d;
    logic              valid_q, valid_d;
    logic              fire;

    // Taken/not-taken is already folded into BTB_validDest_i by the BTB.
    logic              unused_take;
    assign unused_take = BTB_validTake_i;

    assign fire = valid_q && IF_ready_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        saved_dest_d = saved_dest_q;
        seq_d        = seq_q;
        epoch_d      = epoch_q;
        valid_d      = 1'b1;

        if (BCK_redirect_i) begin
            pc_d    = BCK_redirectDest_i;
            state_d = ST_NORMAL;
            epoch_d = ~epoch_q;
            seq_d   = '0;
        end else if (fire) begin
            seq_d = seq_q + SEQ_ONE;
            case (state_q)
                ST_NORMAL: begin
                    if (BTB_needDelaySlot_i) begin
                        saved_dest_d = BTB_validDest_i;
                        pc_d         = BTB_fifthVAddr_i;
                        state_d      = ST_DSLOT;
                    end else begin
                        pc_d = BTB_validDest_i;
                    end
                end
                ST_DSLOT: begin
                    pc_d    = saved_dest_q;
                    state_d = ST_NORMAL;
                end
                default: begin
                    state_d = ST_NORMAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            pc_q         <= RESET_VECTOR;
            saved_dest_q <= '0;
            seq_q        <= '0;
            epoch_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            saved_dest_q <= saved_dest_d;
            seq_q        <= seq_d;
            epoch_q      <= epoch_d;
            valid_q      <= valid_d;
        end
    end

    assign PCG_VAddr_p_o       = pack_slot_addrs(pc_q);
    assign PCG_instEnable_o    = slot_mask(state_q, pc_q[3:2]);
    assign PCG_needDelaySlot_o = (state_q == ST_DSLOT);
    assign PCG_valid_o         = valid_q;
    assign PCG_seq_o           = seq_q;
    assign PCG_epoch_o         = epoch_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen with a behavioural fetch model
module tb_fetch_pc_gen;

    logic         clk;
    logic         rst;
    logic         BCK_redirect_i;
    logic [31:0]  BCK_redirectDest_i;
    logic         IF_ready_i;
    logic [31:0]  BTB_validDest_i;
    logic         BTB_validTake_i;
    logic         BTB_needDelaySlot_i;
    logic [31:0]  BTB_fifthVAddr_i;
    logic [127:0] PCG_VAddr_p_o;
    logic [3:0]   PCG_instEnable_o;
    logic         PCG_needDelaySlot_o;
    logic         PCG_valid_o;
    logic [2:0]   PCG_seq_o;
    logic         PCG_epoch_o;

    fetch_pc_gen dut (
        .clk                 (clk),
        .rst                 (rst),
        .BCK_redirect_i      (BCK_redirect_i),
        .BCK_redirectDest_i  (BCK_redirectDest_i),
        .IF_ready_i          (IF_ready_i),
        .BTB_validDest_i     (BTB_validDest_i),
        .BTB_validTake_i     (BTB_validTake_i),
        .BTB_needDelaySlot_i (BTB_needDelaySlot_i),
        .BTB_fifthVAddr_i    (BTB_fifthVAddr_i),
        .PCG_VAddr_p_o       (PCG_VAddr_p_o),
        .PCG_instEnable_o    (PCG_instEnable_o),
        .PCG_needDelaySlot_o (PCG_needDelaySlot_o),
        .PCG_valid_o         (PCG_valid_o),
        .PCG_seq_o           (PCG_seq_o),
        .PCG_epoch_o         (PCG_epoch_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] addr;
        logic [3:0]   en;
        logic         nds;
        logic [2:0]   seq;
        logic         ep;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: the fetch address, a pending jump target, and group counters.
    logic [31:0] m_pc;
    logic [31:0] m_saved;
    bit          m_in_dslot;
    int          m_seq;
    bit          m_epoch;
    bit          m_valid;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        int   slot;
        slot  = int'((m_pc >> 2) & 32'd3);
        e.en  = '0;
        for (int i = 0; i < 4; i++) begin
            e.addr[32*i +: 32] = (m_pc & 32'hFFFF_FFF3) | 32'(i * 4);
            e.en[i] = m_in_dslot ? (i == slot) : (i >= slot);
        end
        e.nds = m_in_dslot;
        e.seq = 3'(m_seq);
        e.ep  = m_epoch;
        return e;
    endfunction

    task automatic model_reset();
        m_pc       = 32'hBFC0_0000;
        m_saved    = 32'h0;
        m_in_dslot = 1'b0;
        m_seq      = 0;
        m_epoch    = 1'b0;
        m_valid    = 1'b0;
    endtask

    // Called at posedge+1: drive this cycle's inputs, advance the model across the coming edge.
    task automatic step(input bit r, input bit redir, input logic [31:0] rdest, input bit rdy,
                        input logic [31:0] dest, input bit nds, input bit seq_dest);
        logic [31:0] fifth;
        logic [31:0] d;
        fifth = m_pc + 32'h10 - (m_pc & 32'hF);
        d     = seq_dest ? fifth : dest;
        rst                 = r;
        BCK_redirect_i      = redir;
        BCK_redirectDest_i  = rdest;
        IF_ready_i          = rdy;
        BTB_validDest_i     = d;
        BTB_validTake_i     = !seq_dest;
        BTB_needDelaySlot_i = nds;
        BTB_fifthVAddr_i    = fifth;
        if (r) begin
            model_reset();
        end else begin
            if (redir) begin
                m_pc       = rdest;
                m_in_dslot = 1'b0;
                m_epoch    = !m_epoch;
                m_seq      = 0;
            end else if (m_valid && rdy) begin
                if (m_in_dslot) begin
                    m_pc       = m_saved;
                    m_in_dslot = 1'b0;
                end else if (nds) begin
                    m_saved    = d;
                    m_pc       = fifth;
                    m_in_dslot = 1'b1;
                end else begin
                    m_pc = d;
                end
                m_seq = (m_seq + 1) % 8;
            end
            m_valid = 1'b1;
            sb.push_back(expect_now());
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (PCG_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_group", {127'b0, PCG_valid_o}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_addr", PCG_VAddr_p_o, e.addr);
                chk("sb_en", {124'b0, PCG_instEnable_o}, {124'b0, e.en});
                chk("sb_nds", {127'b0, PCG_needDelaySlot_o}, {127'b0, e.nds});
                chk("sb_seq", {125'b0, PCG_seq_o}, {125'b0, e.seq});
                chk("sb_epoch", {127'b0, PCG_epoch_o}, {127'b0, e.ep});
            end
        end
    end

    initial begin
        rst = 1'b1;
        BCK_redirect_i = 1'b0;
        BCK_redirectDest_i = '0;
        IF_ready_i = 1'b0;
        BTB_validDest_i = '0;
        BTB_validTake_i = 1'b0;
        BTB_needDelaySlot_i = 1'b0;
        BTB_fifthVAddr_i = '0;
        model_reset();
        @(posedge clk);
        #1;

        step(1, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 1);
        chk("rst_valid", {127'b0, PCG_valid_o}, 128'd0);
        chk("rst_seq", {125'b0, PCG_seq_o}, 128'd0);
        chk("rst_epoch", {127'b0, PCG_epoch_o}, 128'd0);
        chk("rst_en", {124'b0, PCG_instEnable_o}, 128'hF);

        step(0, 0, 0, 1, 0, 0, 1);
        chk("grp0_addr", {96'b0, PCG_VAddr_p_o[31:0]}, 128'hBFC0_0000);
        chk("grp0_valid", {127'b0, PCG_valid_o}, 128'd1);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("grp1_addr", {96'b0, PCG_VAddr_p_o[31:0]}, 128'hBFC0_0010);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("grp2_addr", {96'b0, PCG_VAddr_p_o[31:0]}, 128'hBFC0_0020);
        chk("grp2_seq", {125'b0, PCG_seq_o}, 128'd2);

        step(0, 1, 32'h8000_0008, 1, 32'h1234_5678, 0, 0);
        chk("mid_en", {124'b0, PCG_instEnable_o}, 128'hC);
        chk("mid_addrs", PCG_VAddr_p_o, 128'h8000000C_80000008_80000004_80000000);

        step(0, 1, 32'h8000_0100, 1, 0, 0, 1);
        step(0, 0, 0, 1, 32'h8000_2000, 1, 0);
        chk("dslot_addr", {96'b0, PCG_VAddr_p_o[31:0]}, 128'h8000_0110);
        chk("dslot_en", {124'b0, PCG_instEnable_o}, 128'h1);
        chk("dslot_flag", {127'b0, PCG_needDelaySlot_o}, 128'd1);
        step(0, 0, 0, 1, 32'hDEAD_BEE0, 1, 0);
        chk("dslot_target", {96'b0, PCG_VAddr_p_o[31:0]}, 128'h8000_2000);
        chk("dslot_exit", {127'b0, PCG_needDelaySlot_o}, 128'd0);

        step(0, 1, 32'h8000_0200, 1, 0, 0, 1);
        step(0, 0, 0, 1, 32'h8000_3000, 1, 0);
        step(0, 1, 32'h8000_4000, 0, 32'h5555_0000, 1, 0);
        chk("redir_dslot_addr", {96'b0, PCG_VAddr_p_o[31:0]}, 128'h8000_4000);
        chk("redir_dslot_flag", {127'b0, PCG_needDelaySlot_o}, 128'd0);
        chk("redir_dslot_seq", {125'b0, PCG_seq_o}, 128'd0);
        chk("redir_dslot_epoch", {127'b0, PCG_epoch_o}, 128'd0);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("no_saved_dest", {96'b0, PCG_VAddr_p_o[31:0]}, 128'h8000_4010);

        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, $urandom, 1'($urandom), 0);
        end
        step(0, 0, 0, 1, 32'h8000_5550, 0, 0);
        chk("stall_release", {96'b0, PCG_VAddr_p_o[31:0]}, 128'h8000_5550);

        step(0, 1, 32'h8000_6000, 1, 0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            step(0, 0, 0, 1, 0, 0, 1);
        end
        chk("seq_wrap", {125'b0, PCG_seq_o}, 128'd1);
        step(1, 1, 32'h8000_7000, 1, 0, 0, 1);
        chk("rst_pulse_valid", {127'b0, PCG_valid_o}, 128'd0);
        chk("rst_pulse_addr", {96'b0, PCG_VAddr_p_o[31:0]}, 128'hBFC0_0000);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("rst_pulse_recover", {127'b0, PCG_valid_o}, 128'd1);

        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 199) == 0, ($urandom % 16) == 0, $urandom,
                 ($urandom % 4) != 0, $urandom, ($urandom % 4) == 0, 1'($urandom));
        end

        step(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        chk("sb_drain", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
